// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter onto a single-beat AXI4 data-memory master
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise port 1 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_we,
  input  logic [5:0]          req_size,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [63:0]         req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          resp_valid,
  output logic [31:0]         resp_rdata,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arsize,
  output logic                arvalid,
  input  logic                arready,
  input  logic [31:0]         rdata,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready
);

  typedef enum logic [1:0] {IDLE, RD, WR, WB} state_t;

  state_t state;
  logic   grant;
`ifdef MEM_ARB_RR_EN
  logic   last_grant;
`endif

  logic              sel;
  logic              sel_we;
  logic [2:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_byte;

  always_comb begin
`ifdef MEM_ARB_RR_EN
    if (&req_valid) sel = ~last_grant;
    else            sel = req_valid[1];
`else
    sel = req_valid[1];
`endif
    sel_we    = req_we[sel];
    sel_size  = sel ? req_size[5:3] : req_size[2:0];
    sel_addr  = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_wdata = sel ? req_wdata[63:32] : req_wdata[31:0];
    sel_byte  = (sel_size == 3'b000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant <= 1'b0;
`endif
      req_ready  <= 2'b00;
      resp_valid <= 2'b00;
      resp_rdata <= '0;
      araddr     <= '0;
      arsize     <= '0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= '0;
      awsize     <= '0;
      awvalid    <= 1'b0;
      wdata      <= '0;
      wstrb      <= '0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
    end else begin
      req_ready  <= 2'b00;
      resp_valid <= 2'b00;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant     <= sel;
`ifdef MEM_ARB_RR_EN
            last_grant <= sel;
`endif
            req_ready <= 2'b01 << sel;
            if (sel_we) begin
              awaddr  <= sel_addr;
              awsize  <= sel_size;
              // byte stores replicate onto every lane; strobe picks the lane
              wdata   <= sel_byte ? {4{sel_wdata[7:0]}} : sel_wdata;
              wstrb   <= sel_byte ? (4'b0001 << sel_addr[1:0]) : 4'hf;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              bready  <= 1'b1;
              state   <= WR;
            end else begin
              araddr  <= sel_addr;
              arsize  <= sel_size;
              arvalid <= 1'b1;
              rready  <= 1'b1;
              state   <= RD;
            end
          end
        end
        RD: begin
          if (arvalid && arready) arvalid <= 1'b0;
          if (rvalid && rready) begin
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            resp_rdata <= rdata;
            resp_valid <= 2'b01 << grant;
            state      <= IDLE;
          end
        end
        WR: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          // B is only considered once both AW and W are through
          if ((!awvalid || awready) && (!wvalid || wready)) state <= WB;
        end
        WB: begin
          if (bvalid && bready) begin
            bready     <= 1'b0;
            resp_valid <= 2'b01 << grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;
  localparam int ADDR_W = 22;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          req_valid;
  logic [1:0]          req_we;
  logic [5:0]          req_size;
  logic [2*ADDR_W-1:0] req_addr;
  logic [63:0]         req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          resp_valid;
  logic [31:0]         resp_rdata;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arsize;
  logic                arvalid;
  logic                arready;
  logic [31:0]         rdata;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awsize;
  logic                awvalid;
  logic                awready;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wvalid;
  logic                wready;
  logic                bvalid;
  logic                bready;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  logic [126:0] all_out;
  assign all_out = {req_ready, resp_valid, resp_rdata, araddr, arsize, arvalid, rready,
                    awaddr, awsize, awvalid, wdata, wstrb, wvalid, bready};

  typedef struct {
    bit          port;
    bit          we;
    logic [2:0]  size;
    logic [21:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          a_at;
    int          d_at;
    int          b_at;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
  } vec_t;

  vec_t vecs[7];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  task automatic apply(input vec_t v, input int id);
    int          k;
    int          done_k;
    int          resp_cnt;
    bit          a_done, d_done, b_done;
    bit          hs_a, hs_d, hs_b;
    bit          proto_ok, resp_ok;
    logic [31:0] got_rd;
    string       tag;
    tag = $sformatf("v%0d", id);
    req_valid[v.port] = 1'b1;
    req_we[v.port]    = v.we;
    if (v.port) begin
      req_size[5:3]                = v.size;
      req_addr[2*ADDR_W-1:ADDR_W]  = v.addr;
      req_wdata[63:32]             = v.wd;
    end else begin
      req_size[2:0]                = v.size;
      req_addr[ADDR_W-1:0]         = v.addr;
      req_wdata[31:0]              = v.wd;
    end
    tick();
    chk({tag, "_req_ready"}, req_ready, 2'b01 << v.port);
    chk({tag, "_valids"}, {arvalid, rready, awvalid, wvalid, bready}, v.we ? 5'b00111 : 5'b11000);
    if (v.we) begin
      chk({tag, "_awaddr"}, awaddr, v.addr);
      chk({tag, "_awsize"}, awsize, v.size);
      chk({tag, "_wdata"}, wdata, v.exp_wdata);
      chk({tag, "_wstrb"}, wstrb, v.exp_wstrb);
    end else begin
      chk({tag, "_araddr"}, araddr, v.addr);
      chk({tag, "_arsize"}, arsize, v.size);
    end
    req_valid[v.port] = 1'b0;
    rdata = v.rd;
    k = 0; done_k = -1; resp_cnt = 0; proto_ok = 1; resp_ok = 1; got_rd = '0;
    a_done = 0; d_done = 0; b_done = 0;
    while (k < 40 && !(done_k >= 0 && k > done_k + 2)) begin
      if (v.we) begin
        if (awvalid !== ~a_done || wvalid !== ~d_done || bready !== ~b_done) proto_ok = 0;
        if (arvalid !== 1'b0 || rready !== 1'b0) proto_ok = 0;
      end else begin
        if (arvalid !== ~a_done || rready !== ~d_done) proto_ok = 0;
        if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0) proto_ok = 0;
      end
      if (resp_valid != 2'b00) begin
        resp_cnt++;
        got_rd = resp_rdata;
        if (resp_valid != (2'b01 << v.port) || done_k < 0 || k != done_k + 1) resp_ok = 0;
      end
      if (v.we) begin
        awready = (k >= v.a_at);
        wready  = (k >= v.d_at);
        bvalid  = (k >= v.b_at) && a_done && d_done && !b_done;
        hs_a = awvalid && awready;
        hs_d = wvalid && wready;
        hs_b = bvalid && bready;
      end else begin
        arready = (k >= v.a_at);
        rvalid  = (k >= v.d_at) && !d_done;
        hs_a = arvalid && arready;
        hs_d = rvalid && rready;
        hs_b = 0;
      end
      if ((v.we && hs_b) || (!v.we && hs_d)) done_k = k;
      tick();
      a_done |= hs_a;
      d_done |= hs_d;
      b_done |= hs_b;
      k++;
    end
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    chk({tag, "_protocol"}, proto_ok, 1'b1);
    chk({tag, "_resp_count"}, resp_cnt, 1);
    chk({tag, "_resp_timing"}, resp_ok, 1'b1);
    if (!v.we) chk({tag, "_resp_rdata"}, got_rd, v.rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   grants[$];
    int   exp_g[4];
    int   nresp;
    int   ncyc;
    bit   prev_ar;
    bit   quiet;

    req_valid = '0; req_we = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    arready = 0; rdata = '0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;

    vecs[0] = '{port:1'b0, we:1'b0, size:3'b010, addr:22'h000100, wd:32'h0, rd:32'hDEADBEEF,
                a_at:2, d_at:4, b_at:0, exp_wdata:32'h0, exp_wstrb:4'h0};
    vecs[1] = '{port:1'b1, we:1'b1, size:3'b000, addr:22'h000203, wd:32'h000000A5, rd:32'h0,
                a_at:1, d_at:0, b_at:2, exp_wdata:32'hA5A5A5A5, exp_wstrb:4'b1000};
    vecs[2] = '{port:1'b0, we:1'b1, size:3'b010, addr:22'h000040, wd:32'h12345678, rd:32'h0,
                a_at:3, d_at:0, b_at:0, exp_wdata:32'h12345678, exp_wstrb:4'hf};
    vecs[3] = '{port:1'b1, we:1'b0, size:3'b000, addr:22'h000007, wd:32'h0, rd:32'h000000C3,
                a_at:0, d_at:0, b_at:0, exp_wdata:32'h0, exp_wstrb:4'h0};
    vecs[4] = '{port:1'b0, we:1'b1, size:3'b000, addr:22'h000001, wd:32'h1234563C, rd:32'h0,
                a_at:0, d_at:0, b_at:0, exp_wdata:32'h3C3C3C3C, exp_wstrb:4'b0010};
    vecs[5] = '{port:1'b1, we:1'b1, size:3'b010, addr:22'h3FFFFC, wd:32'hCAFEF00D, rd:32'h0,
                a_at:2, d_at:2, b_at:5, exp_wdata:32'hCAFEF00D, exp_wstrb:4'hf};
    vecs[6] = '{port:1'b0, we:1'b0, size:3'b010, addr:22'h3FFFF0, wd:32'h0, rd:32'h80000001,
                a_at:1, d_at:1, b_at:0, exp_wdata:32'h0, exp_wstrb:4'h0};

    #1 rst = 1'b1;
    tick();
    tick();
    chk("reset_outputs", all_out, '0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", all_out, '0);

    for (int i = 0; i < 7; i++) apply(vecs[i], i);

    // contention: both ports request continuously, reads only
`ifdef MEM_ARB_RR_EN
    exp_g = '{1, 0, 1, 0};
`else
    exp_g = '{1, 1, 1, 1};
`endif
    req_we = 2'b00; req_size = 6'b010_010; req_addr = {22'h000020, 22'h000010};
    req_valid = 2'b11; nresp = 0; ncyc = 0; prev_ar = 0;
    tick();
    while (nresp < 4 && ncyc < 200) begin
      if (resp_valid != 2'b00) nresp++;
      for (int p = 0; p < 2; p++) begin
        if (req_ready[p]) begin
          grants.push_back(p);
          req_valid[p] = 1'b0;
        end else begin
          req_valid[p] = (grants.size() < 4);
        end
      end
      arready = arvalid && prev_ar;
      rvalid  = rready && !arvalid;
      rdata   = 32'h11110000 + nresp;
      prev_ar = arvalid;
      tick();
      ncyc++;
    end
    req_valid = 2'b00; arready = 0; rvalid = 0;
    tick();
    chk("contend_resps", nresp, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("contend_grant%0d", i), (i < grants.size()) ? grants[i] : 99, exp_g[i]);

    // reset while a read is waiting on arready
    req_we = 2'b00; req_size = 6'b000_010; req_addr = {22'h0, 22'h000080};
    req_valid = 2'b01;
    tick();
    chk("rst_rd_req_ready", req_ready, 2'b01);
    req_valid = 2'b00;
    tick();
    chk("rst_rd_arvalid", {arvalid, rready}, 2'b11);
    #2 rst = 1'b1;
    #1 chk("rst_async_outputs", all_out, '0);
    rvalid = 1; rdata = 32'h55555555;
    quiet = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (all_out != '0) quiet = 0;
    end
    rvalid = 0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (resp_valid != 2'b00 || arvalid) quiet = 0;
    end
    chk("rst_no_resp", quiet, 1'b1);
    apply(vecs[0], 10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name:
mem_arbiter

Overview:
- Shares the single AXI4 data-memory master between two requesters: port 0 (instruction fetch / program loader) and port 1 (exec-stage LW/LF/LB/SW/SF/SB).
- Serialises accesses, with at most one outstanding transaction. Drives the single-beat AXI read and write channels and returns completion and read data to the granted port.

Parameters:
ADDR_W, 22, byte address width of the AXI and requester address buses

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  2  per-port request; held high until that port's req_ready pulse
req_we  in  2  per-port: 1 = write, 0 = read
req_size  in  6  per-port {p1,p0} AXI size, 3 bits each: 3'b000 byte, 3'b010 word
req_addr  in  2*ADDR_W  per-port byte address {p1,p0}
req_wdata  in  64  per-port write data {p1,p0}; for byte writes, data in bits [7:0]
req_ready  out  2  one-cycle pulse: request accepted
resp_valid  out  2  one-cycle pulse: transaction complete (read data valid / write acknowledged)
resp_rdata  out  32  read data, common to both ports; valid with resp_valid
araddr  out  ADDR_W  read address
arsize  out  3  read size
arvalid  out  1  read address valid
arready  in  1  read address ready
rdata  in  32  read data
rvalid  in  1  read data valid
rready  out  1  read data ready
awaddr  out  ADDR_W  write address
awsize  out  3  write size
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata  out  32  write data; byte writes replicated to all 4 lanes
wstrb  out  4  word write: 4'hf; byte write: 4'b0001 << addr[1:0]
wvalid  out  1  write data valid
wready  in  1  write data ready
bvalid  in  1  write response valid
bready  out  1  write response ready

Behaviour:
- Reset (async, rst=1):
  - State IDLE, grant=0, last_grant=0.
  - All valid, ready and pulse outputs 0.
  - Address, size, wdata, resp_rdata and wstrb outputs 0.
  - Any in-flight AXI transaction is abandoned; no resp_valid is issued for it.
- States: IDLE, RD, WR, WB. All outputs are registered.
- IDLE, with any req_valid high:
  - Select a port. Fixed priority: port 1 wins when both are valid.
  - Latch grant, addr, size and wdata. Pulse req_ready[grant] on the next cycle.
  - Read: set arvalid=1 and rready=1, go to RD.
  - Write: set awvalid=1, wvalid=1 and bready=1, go to WR.
  - Latency: request in cycle N gives arvalid/awvalid and req_ready in cycle N+1.
- RD:
  - arvalid drops in the cycle after arvalid&arready.
  - On rvalid&rready: rready<=0, resp_rdata<=rdata, resp_valid[grant] pulses next cycle, return to IDLE.
  - rvalid arriving in the same cycle as arready is legal and is handled as above.
- WR:
  - awvalid and wvalid each drop independently after their own handshake.
  - When both handshakes are done (same or different cycles), go to WB.
- WB:
  - On bvalid&bready: bready<=0, resp_valid[grant] pulses, return to IDLE.
  - bvalid arriving while still in WR is accepted only after both aw and w handshakes are done.
- Throughput: the cycle after resp_valid is IDLE. The minimum gap between accepted requests is 1 idle cycle. A requester still holding req_valid is re-arbitrated at that point.
- Requester rules:
  - The requester must not change addr, size, we or wdata while req_valid=1 and req_ready has not yet pulsed.
  - The requester must drop req_valid in the cycle after req_ready.
- req_valid deasserted by a requester before it is granted: the request is simply not taken. No error.
- AXI resp fields are ignored. Errors are not reported.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration. On a conflict, the port not equal to last_grant wins. last_grant updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, port 1 always wins. last_grant logic is not compiled.

Test Plan:
- Port 0 word read at 0x000100, arready/rvalid each delayed 2 cycles, rdata=0xDEADBEEF -> req_ready[0] pulses 1 cycle after request; resp_valid[0] pulses with resp_rdata=0xDEADBEEF; araddr=0x000100, arsize=3'b010.
- Port 1 SB to 0x000203, wdata=0xA5 -> awaddr=0x000203, awsize=3'b000, wstrb=4'b1000, wdata=0xA5A5A5A5; resp_valid[1] pulses only after both the aw and w handshakes and bvalid.
- Write with wready 3 cycles before awready -> wvalid drops first, awvalid stays high until awready; exactly one resp_valid.
- Both ports request every cycle, 4 transactions:
  - Fixed priority: all 4 grants go to port 1.
  - With MEM_ARB_RR_EN: grants alternate 1,0,1,0.
- rst asserted while in RD with arvalid=1 -> all outputs 0 asynchronously, no resp_valid; after release, a new port 0 read completes normally.
